// File: rtl/nrd_pkg.sv
// Shared types and helpers for the non-restoring divider controller.
// Signed operation is enabled with NRD_SIGNED_DIV_EN.
package nrd_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/nrd_step.sv
// One non-restoring division iteration: shift A:Q left,
// add or subtract M by the old A sign, then set the quotient bit.
module nrd_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] a_sh;

    assign a_sh   = {a[WIDTH-1:0], q[WIDTH-1]};
    assign a_next = a[WIDTH] ? (a_sh + m) : (a_sh - m);
    assign q_next = {q[WIDTH-2:0], ~a_next[WIDTH]};

endmodule

// File: rtl/nrd_div_ctrl.sv
// Non-restoring division sequencer with start/done handshake.
// Define NRD_SIGNED_DIV_EN for two's-complement operands.
module nrd_div_ctrl
    import nrd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH:0]   a;
    logic [WIDTH:0]   m;
    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   a_nx;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH:0]   a_fix;
    logic [WIDTH-1:0] q_out;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] dd_in;
    logic [WIDTH-1:0] dv_in;

    nrd_step #(.WIDTH(WIDTH)) u_step (
        .a      (a),
        .q      (q),
        .m      (m),
        .a_next (a_nx),
        .q_next (q_nx)
    );

    // Final restore step when the partial remainder ended negative
    assign a_fix = a[WIDTH] ? (a + m) : a;

`ifdef NRD_SIGNED_DIV_EN
    logic q_neg;
    logic r_neg;

    assign dd_in = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign dv_in = divisor[WIDTH-1] ? (~divisor + 1'b1) : divisor;
    assign q_out = q_neg ? (~q + 1'b1) : q;
    assign r_out = r_neg ? (~a_fix[WIDTH-1:0] + 1'b1)
                         : a_fix[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (state == IDLE && start) begin
            q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg <= dividend[WIDTH-1];
        end
    end
`else
    assign dd_in = dividend;
    assign dv_in = divisor;
    assign q_out = q;
    assign r_out = a_fix[WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            a         <= '0;
            q         <= '0;
            m         <= '0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                            state     <= DONE;
                        end else begin
                            a     <= '0;
                            q     <= dd_in;
                            m     <= {1'b0, dv_in};
                            cnt   <= CNT_W'(WIDTH);
                            busy  <= 1'b1;
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    a   <= a_nx;
                    q   <= q_nx;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= FIX;
                end
                FIX: begin
                    a         <= a_fix;
                    quotient  <= q_out;
                    remainder <= r_out;
                    div_zero  <= 1'b0;
                    busy      <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nrd_div_ctrl.sv
// Directed scoreboard bench for nrd_div_ctrl.
// Expected results come from a behavioural division model.
module tb_nrd_div_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    nrd_div_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] dvd,
                                   input logic [7:0] dvs);
        exp_t e;
        int   sd;
        int   sv;
        if (dvs == 8'd0) begin
            e.q  = 8'hFF;
            e.r  = dvd;
            e.dz = 1'b1;
            return e;
        end
`ifdef NRD_SIGNED_DIV_EN
        sd = int'($signed(dvd));
        sv = int'($signed(dvs));
`else
        sd = int'(dvd);
        sv = int'(dvs);
`endif
        e.q  = 8'(sd / sv);
        e.r  = 8'(sd % sv);
        e.dz = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [7:0] dvd, input logic [7:0] dvs,
                        input bit push);
        @(negedge clk);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        if (push) sb.push_back(model(dvd, dvs));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called 1 time unit after an edge; counts edges until done.
    task automatic wait_done(input string tag, input int exp_lat,
                             input int exp_busy);
        int   lat  = 0;
        int   bcnt = 0;
        bit   seen = 1'b0;
        exp_t e;
        if (busy) bcnt++;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                lat  = i;
            end else if (busy) begin
                bcnt++;
            end
        end
        chk({tag, "_seen"}, 16'(seen), 16'd1);
        if (seen) begin
            chk({tag, "_lat"}, 16'(lat), 16'(exp_lat));
            chk({tag, "_busy"}, 16'(bcnt), 16'(exp_busy));
            if (sb.size() == 0) begin
                chk({tag, "_sb"}, 16'd0, 16'd1);
            end else begin
                e = sb.pop_front();
                chk({tag, "_q"}, 16'(quotient), 16'(e.q));
                chk({tag, "_r"}, 16'(remainder), 16'(e.r));
                chk({tag, "_dz"}, 16'(div_zero), 16'(e.dz));
            end
            @(posedge clk);
            #1;
            chk({tag, "_pulse"}, 16'(done), 16'd0);
        end
    endtask

    task automatic no_done(input string tag, input int n);
        bit hit = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) hit = 1'b1;
        end
        chk(tag, 16'(hit), 16'd0);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_q", 16'(quotient), 16'd0);
        chk("rst_r", 16'(remainder), 16'd0);
        chk("rst_dz", 16'(div_zero), 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        send(8'd100, 8'd7, 1'b1);
        wait_done("d100_7", 10, 9);
        send(8'd255, 8'd1, 1'b1);
        wait_done("d255_1", 10, 9);
        send(8'd5, 8'd9, 1'b1);
        wait_done("d5_9", 10, 9);
        send(8'h3C, 8'd0, 1'b1);
        wait_done("dzero", 1, 0);

        // second start while ITER must be ignored
        send(8'd100, 8'd7, 1'b1);
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore2nd", 9, 8);
        no_done("noqueue", 14);

        // reset in the middle of an operation
        send(8'd33, 8'd4, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_busy", 16'(busy), 16'd0);
        chk("mid_done", 16'(done), 16'd0);
        chk("mid_q", 16'(quotient), 16'd0);
        chk("mid_r", 16'(remainder), 16'd0);
        chk("mid_dz", 16'(div_zero), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        no_done("mid_nodone", 14);
        send(8'd200, 8'd13, 1'b1);
        wait_done("d200_13", 10, 9);

        // start held high: accepted again right after done
        send(8'd100, 8'd7, 1'b1);
        start    = 1'b1;
        dividend = 8'd99;
        divisor  = 8'd10;
        sb.push_back(model(8'd99, 8'd10));
        wait_done("b2b_1", 10, 9);
        start = 1'b0;
        wait_done("b2b_2", 10, 9);

`ifdef NRD_SIGNED_DIV_EN
        send(8'h9C, 8'd7, 1'b1);
        wait_done("sneg100_7", 10, 9);
        send(8'h80, 8'hFF, 1'b1);
        wait_done("smin_m1", 10, 9);
`endif

        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
